word_serializer: RTL and testbench

Parallel-to-serial transmit stage directly downstream of the 9-bit output register. It accepts one 9-bit word (8 data bits plus an even-parity bit in bit 8) on a load strobe and shifts it out LSB-first on a single line. Each frame is one start bit, the word, and one stop bit, with every bit held for a programmable number of clocks. Busy and done flags let the upstream register/controller pace word delivery.

---
 rtl/serializer_pkg.sv | 9 +
 rtl/word_serializer_bit_timer.sv | 16 +
 rtl/word_serializer.sv | 81 ++++++++
 tb/tb_word_serializer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding, default geometry and frame-length helper for word_serializer.
package serializer_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DEF_WIDTH = 9;
  localparam int DEF_BAUD_DIV = 4;
  function automatic int frame_cycles(input int width, input int div);
    return (width + 2) * div;
  endfunction
endpackage

// File: rtl/word_serializer_bit_timer.sv
// bit_timer: modulo-DIV baud counter with synchronous clear, ticking on the last count of each bit.
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clr || cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
  assign tick = !clr && cnt == CW'(DIV - 1);
endmodule

// File: rtl/word_serializer.sv
// word_serializer: start/word/stop serial transmitter, LSB first, BAUD_DIV clocks per bit.
// Define PARITY_CHECK_EN to reject words whose even-parity bit is wrong.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic             parity_err
);
  localparam int BW = $clog2(WIDTH);
  state_t state, state_d;
  logic [WIDTH-1:0] shift, shift_d;
  logic [BW-1:0] bit_cnt, bit_d;
  logic done_q, done_d, perr_q, perr_d, tick, ok;
`ifdef PARITY_CHECK_EN
  assign ok = data[WIDTH-1] == ^data[WIDTH-2:0];
`else
  assign ok = 1'b1;
`endif
  bit_timer #(.DIV(BAUD_DIV)) u_timer (.clk, .rst, .clr(state == IDLE), .tick);
  always_comb begin
    state_d = state;
    shift_d = shift;
    bit_d = bit_cnt;
    done_d = 1'b0;
    perr_d = 1'b0;
    case (state)
      IDLE: if (load) begin
        if (ok) begin
          state_d = START;
          shift_d = data;
          bit_d = '0;
        end else perr_d = 1'b1;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (tick) begin
        shift_d = shift >> 1;
        bit_d = bit_cnt + BW'(1);
        state_d = bit_cnt == BW'(WIDTH - 1) ? STOP : DATA;
      end
      STOP: if (tick) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      done_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state <= state_d;
      shift <= shift_d;
      bit_cnt <= bit_d;
      done_q <= done_d;
      perr_q <= perr_d;
    end
  assign ser_out = state == DATA ? shift[0] : state != START;
  assign busy = state != IDLE;
  assign done = done_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: scoreboard bench for word_serializer (default and BAUD_DIV=1 instances).
module tb_word_serializer;
  import serializer_pkg::*;
  logic clk = 1'b0, rst = 1'b0, load = 1'b0, load1 = 1'b0;
  logic [8:0] data = '0, data1 = '0;
  logic ser_out, busy, done, parity_err, ser1, busy1, done1, perr1;
  int total = 0, bad = 0;
  logic exp_q[$];
  always #5 clk = ~clk;

  word_serializer dut (.clk(clk), .rst(rst), .load(load), .data(data),
    .ser_out(ser_out), .busy(busy), .done(done), .parity_err(parity_err));
  word_serializer #(.WIDTH(9), .BAUD_DIV(1)) dut1 (.clk(clk), .rst(rst), .load(load1), .data(data1),
    .ser_out(ser1), .busy(busy1), .done(done1), .parity_err(perr1));

  function automatic void push_frame(input logic [8:0] w, input int div);
    for (int j = 0; j < div; j++) exp_q.push_back(1'b0);
    for (int b = 0; b < 9; b++) for (int j = 0; j < div; j++) exp_q.push_back(w[b]);
    for (int j = 0; j < div; j++) exp_q.push_back(1'b1);
  endfunction

  task automatic start_load(input logic [8:0] w);
    load = 1'b1;
    data = w;
    push_frame(w, 4);
    @(negedge clk);
    load = 1'b0;
    data = 9'($urandom);
  endtask

  task automatic check_frame(input int inj);
    logic e;
    for (int i = 0; i < frame_cycles(9, 4); i++) begin
      e = exp_q.pop_front();
      total++;
      if (ser_out !== e) begin bad++; $display("FAIL ser_out cyc=%0d got=%b exp=%b", i, ser_out, e); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_frame cyc=%0d got=%b exp=1", i, busy); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL done_in_frame cyc=%0d got=%b exp=0", i, done); end
      total++;
      if (parity_err !== 1'b0) begin bad++; $display("FAIL perr_in_frame cyc=%0d got=%b exp=0", i, parity_err); end
      if (i == inj) begin load = 1'b1; data = 9'h000; end
      if (i == inj + 1) load = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_done();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_at_done got=%b exp=0", busy); end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL done_pulse got=%b exp=1", done); end
  endtask

  task automatic check_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      total++;
      if (ser_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || parity_err !== 1'b0) begin
        bad++;
        $display("FAIL %s cyc=%0d got ser/busy/done/perr=%b%b%b%b exp=1000", tag, i, ser_out, busy, done, parity_err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic e;
    total++;
    if ({ser_out, busy, done, parity_err} !== 4'b1000) begin
      bad++; $display("FAIL reset_state got=%b exp=1000", {ser_out, busy, done, parity_err});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_load(9'h1A5);
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      total++;
      if (ser_out !== e) begin bad++; $display("FAIL pre_reset_ser cyc=%0d got=%b exp=%b", i, ser_out, e); end
      @(negedge clk);
    end
    exp_q.delete();
    rst = 1'b0;
    #1;
    total++;
    if ({ser_out, busy, done} !== 3'b100) begin
      bad++; $display("FAIL midframe_reset got=%b exp=100", {ser_out, busy, done});
    end
    @(negedge clk);
    rst = 1'b1;
    check_idle(10, "post_reset_idle");
  endtask

  task automatic test_single();
    start_load(9'h101);
    check_frame(-1);
    check_done();
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", done); end
    check_idle(3, "single_idle");
  endtask

  task automatic test_back_to_back();
    start_load(9'h055);
    check_frame(-1);
    check_done();
    start_load(9'h0FF);
    check_frame(-1);
    check_done();
    @(negedge clk);
    check_idle(3, "b2b_idle");
  endtask

  task automatic test_load_busy();
    start_load(9'h0FF);
    check_frame(9);
    check_done();
    @(negedge clk);
    check_idle(6, "no_extra_frame");
  endtask

  task automatic test_parity();
`ifdef PARITY_CHECK_EN
    load = 1'b1;
    data = 9'h155;
    @(negedge clk);
    load = 1'b0;
    total++;
    if ({parity_err, busy, ser_out} !== 3'b101) begin
      bad++; $display("FAIL parity_reject got perr/busy/ser=%b exp=101", {parity_err, busy, ser_out});
    end
    @(negedge clk);
    check_idle(5, "parity_after");
`else
    start_load(9'h155);
    check_frame(-1);
    check_done();
    @(negedge clk);
    check_idle(2, "parity_off_idle");
`endif
  endtask

  task automatic test_div1();
    logic e;
    load1 = 1'b1;
    data1 = 9'h0FF;
    push_frame(9'h0FF, 1);
    @(negedge clk);
    load1 = 1'b0;
    data1 = 9'h000;
    for (int i = 0; i < frame_cycles(9, 1); i++) begin
      e = exp_q.pop_front();
      total++;
      if (ser1 !== e || busy1 !== 1'b1 || done1 !== 1'b0) begin
        bad++; $display("FAIL div1_frame cyc=%0d got ser/busy/done=%b%b%b exp=%b10", i, ser1, busy1, done1, e);
      end
      @(negedge clk);
    end
    total++;
    if ({busy1, done1, ser1} !== 3'b011) begin
      bad++; $display("FAIL div1_done got busy/done/ser=%b exp=011", {busy1, done1, ser1});
    end
    @(negedge clk);
    total++;
    if ({busy1, done1} !== 2'b00) begin bad++; $display("FAIL div1_idle got busy/done=%b exp=00", {busy1, done1}); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_load_busy();
    test_parity();
    test_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
